// File: rtl/ula_pkg.sv
// Shared types and widths for the byte-serial 16-bit ALU sequencer.
package ula_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam int S_W    = 4;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    // Operation captured at accept time and held for both byte phases.
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [S_W-1:0]    s;
        logic              m;
        logic              c_in;
    } req_t;

endpackage

// File: rtl/ula_seq16.sv
// Runs a 16-bit operation through an external 8-bit ALU as two byte phases (low, then high).
// Optional ULA_SEQ16_STATUS_EN adds registered rsp_zero / rsp_neg flags.
module ula_seq16
    import ula_pkg::*;
#(
    parameter int ALU_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WORD_W-1:0] req_a,
    input  logic [WORD_W-1:0] req_b,
    input  logic [S_W-1:0]    req_s,
    input  logic              req_m,
    input  logic              req_c_in,

    output logic [BYTE_W-1:0] alu_a,
    output logic [BYTE_W-1:0] alu_b,
    output logic [S_W-1:0]    alu_s,
    output logic              alu_m,
    output logic              alu_c_in,
    input  logic [BYTE_W-1:0] alu_f,
    input  logic              alu_c_out,
    input  logic              alu_a_eq_b,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_f,
    output logic              rsp_c_out,
    output logic              rsp_a_eq_b
`ifdef ULA_SEQ16_STATUS_EN
    ,
    output logic              rsp_zero,
    output logic              rsp_neg
`endif
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ALU_WAIT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    req_t             op;
    logic             carry_lo;
    logic             eq_lo;
    logic             ld_req;
    logic             ld_lo;
    logic             ld_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Idle/response phases park the ALU in logic mode with zero operands.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld_req    = 1'b0;
        ld_lo     = 1'b0;
        ld_hi     = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_s     = '0;
        alu_m     = 1'b1;
        alu_c_in  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    ld_req    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = LO;
                end
            end
            LO: begin
                alu_a    = op.a[BYTE_W-1:0];
                alu_b    = op.b[BYTE_W-1:0];
                alu_s    = op.s;
                alu_m    = op.m;
                alu_c_in = op.c_in;
                if (cnt == WAIT_LAST) begin
                    ld_lo     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = HI;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HI: begin
                alu_a    = op.a[WORD_W-1:BYTE_W];
                alu_b    = op.b[WORD_W-1:BYTE_W];
                alu_s    = op.s;
                alu_m    = op.m;
                // Raw low-byte carry, independent of mode.
                alu_c_in = carry_lo;
                if (cnt == WAIT_LAST) begin
                    ld_hi     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op         <= '0;
            carry_lo   <= 1'b0;
            eq_lo      <= 1'b0;
            rsp_f      <= '0;
            rsp_c_out  <= 1'b0;
            rsp_a_eq_b <= 1'b0;
        end else begin
            if (ld_req) begin
                op.a    <= req_a;
                op.b    <= req_b;
                op.s    <= req_s;
                op.m    <= req_m;
                op.c_in <= req_c_in;
            end
            if (ld_lo) begin
                rsp_f[BYTE_W-1:0] <= alu_f;
                carry_lo          <= alu_c_out;
                eq_lo             <= alu_a_eq_b;
            end
            if (ld_hi) begin
                rsp_f[WORD_W-1:BYTE_W] <= alu_f;
                rsp_c_out              <= alu_c_out;
                rsp_a_eq_b             <= eq_lo & alu_a_eq_b;
            end
        end
    end

`ifdef ULA_SEQ16_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
        end else if (ld_hi) begin
            rsp_zero <= ({alu_f, rsp_f[BYTE_W-1:0]} == '0);
            rsp_neg  <= alu_f[BYTE_W-1];
        end
    end
`endif

endmodule

// File: tb/tb_ula_seq16.sv
// Directed bench for ula_seq16: two instances (ALU_WAIT=0 and 2), each driven by a behavioural 8-bit ALU stub.
module tb_ula_seq16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  req_s = '0;
    logic        req_m = 1'b0, req_c_in = 1'b0;
    logic        rsp_ready = 1'b1;
    logic        sel = 1'b0;

    logic        rv0, rv1, rr0, rr1, vv0, vv1, ac0, ac1, am0, am1, cc0, cc1, eq0, eq1;
    logic        fc0, fc1, fe0, fe1;
    logic [7:0]  aa0, aa1, ab0, ab1, ff0, ff1;
    logic [3:0]  as0, as1;
    logic [15:0] rf0, rf1;
`ifdef ULA_SEQ16_STATUS_EN
    logic        z0, z1, n0, n1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stub ALU: logic XOR/AND/OR, or add with carry; returns {eq, c_out, f}.
    function automatic logic [9:0] alu_fn(input logic [7:0] a, b, input logic [3:0] s,
                                          input logic m, cin);
        logic [8:0] sum;
        logic [7:0] f;
        logic       c;
        if (m) begin
            case (s)
                4'b0110: f = a ^ b;
                4'b1011: f = a & b;
                default: f = a | b;
            endcase
            c = 1'b0;
        end else begin
            sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            f   = sum[7:0];
            c   = sum[8];
        end
        return {a == b, c, f};
    endfunction

    assign {fe0, fc0, ff0} = alu_fn(aa0, ab0, as0, am0, ac0);
    assign {fe1, fc1, ff1} = alu_fn(aa1, ab1, as1, am1, ac1);

    assign rv0 = req_valid & ~sel;
    assign rv1 = req_valid & sel;

    ula_seq16 #(.ALU_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_c_in(req_c_in),
        .alu_a(aa0), .alu_b(ab0), .alu_s(as0), .alu_m(am0), .alu_c_in(ac0),
        .alu_f(ff0), .alu_c_out(fc0), .alu_a_eq_b(fe0),
        .rsp_valid(vv0), .rsp_ready(rsp_ready), .rsp_f(rf0), .rsp_c_out(cc0), .rsp_a_eq_b(eq0)
`ifdef ULA_SEQ16_STATUS_EN
        , .rsp_zero(z0), .rsp_neg(n0)
`endif
    );

    ula_seq16 #(.ALU_WAIT(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_c_in(req_c_in),
        .alu_a(aa1), .alu_b(ab1), .alu_s(as1), .alu_m(am1), .alu_c_in(ac1),
        .alu_f(ff1), .alu_c_out(fc1), .alu_a_eq_b(fe1),
        .rsp_valid(vv1), .rsp_ready(rsp_ready), .rsp_f(rf1), .rsp_c_out(cc1), .rsp_a_eq_b(eq1)
`ifdef ULA_SEQ16_STATUS_EN
        , .rsp_zero(z1), .rsp_neg(n1)
`endif
    );

    // Selected-instance view.
    logic        d_ready, d_valid, d_cin, d_c, d_eq;
    logic [7:0]  d_alu_a;
    logic [15:0] d_f;
    assign d_ready = sel ? rr1 : rr0;
    assign d_valid = sel ? vv1 : vv0;
    assign d_cin   = sel ? ac1 : ac0;
    assign d_c     = sel ? cc1 : cc0;
    assign d_eq    = sel ? eq1 : eq0;
    assign d_alu_a = sel ? aa1 : aa0;
    assign d_f     = sel ? rf1 : rf0;
`ifdef ULA_SEQ16_STATUS_EN
    logic d_z, d_n, got_z, got_n;
    assign d_z = sel ? z1 : z0;
    assign d_n = sel ? n1 : n0;
`endif

    int          lat, width;
    logic [15:0] got_f;
    logic        got_c, got_eq;
    logic [7:0]  tr_a   [1:12];
    logic        tr_cin [1:12];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request, let it be accepted, then scramble the inputs.
    task automatic issue(input logic [15:0] a, b, input logic [3:0] s, input logic m, cin);
        @(negedge clk);
        req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = cin; req_valid = 1'b1;
        chk("ready_idle", {31'd0, d_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = ~a; req_b = ~b; req_c_in = ~cin; req_s = ~s;
    endtask

    // Sample n cycles at the falling edge; k = value seen by edge N+k.
    task automatic watch(input int n);
        lat = 0; width = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tr_a[k]   = d_alu_a;
            tr_cin[k] = d_cin;
            if (d_valid) begin
                if (lat == 0) begin
                    lat = k; got_f = d_f; got_c = d_c; got_eq = d_eq;
`ifdef ULA_SEQ16_STATUS_EN
                    got_z = d_z; got_n = d_n;
`endif
                end
                width++;
            end
        end
    endtask

    task automatic op(input string tag, input logic [15:0] a, b, input logic [3:0] s,
                      input logic m, cin, input logic [15:0] ef, input logic ec, eeq, input int elat);
        issue(a, b, s, m, cin);
        watch(12);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_width"}, width, 1);
        chk({tag, "_f"}, {16'd0, got_f}, {16'd0, ef});
        chk({tag, "_c"}, {31'd0, got_c}, {31'd0, ec});
        chk({tag, "_eq"}, {31'd0, got_eq}, {31'd0, eeq});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready0", {31'd0, rr0}, 1);
        chk("rst_ready1", {31'd0, rr1}, 1);
        chk("rst_valid0", {31'd0, vv0}, 0);
        chk("rst_f0", {16'd0, rf0}, 0);
        chk("rst_c0", {31'd0, cc0}, 0);
        chk("rst_eq0", {31'd0, eq0}, 0);
        chk("rst_alu_m", {31'd0, am0}, 1);
        chk("rst_alu_a", {24'd0, aa0}, 0);
        chk("rst_alu_cin", {31'd0, ac0}, 0);

        // Logic XOR, 3-cycle latency
        op("xor", 16'h00FF, 16'h0F0F, 4'b0110, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 3);
        chk("xor_lo_alu_a", {24'd0, tr_a[1]}, 32'hFF);
        chk("xor_hi_alu_a", {24'd0, tr_a[2]}, 32'h00);
        chk("idle_alu_m", {31'd0, am0}, 1);

        // Carry chain: low byte carries, high byte does not
        op("add", 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 3);
        chk("add_lo_cin", {31'd0, tr_cin[1]}, 0);
        chk("add_hi_cin", {31'd0, tr_cin[2]}, 1);
        op("add_wrap", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3);
        op("add_cin", 16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0, 3);
        chk("add_cin_lo", {31'd0, tr_cin[1]}, 1);

        // Equality: low equal only, then both equal
        op("eq_lo", 16'h1234, 16'h5634, 4'b0110, 1'b1, 1'b0, 16'h4400, 1'b0, 1'b0, 3);
        op("eq_all", 16'hABCD, 16'hABCD, 4'b0110, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 3);

`ifdef ULA_SEQ16_STATUS_EN
        op("st_zero", 16'h8001, 16'h8001, 4'b0110, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 3);
        chk("st_zero_z", {31'd0, got_z}, 1);
        chk("st_zero_n", {31'd0, got_n}, 0);
        op("st_neg", 16'h8000, 16'h0000, 4'b0110, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 3);
        chk("st_neg_z", {31'd0, got_z}, 0);
        chk("st_neg_n", {31'd0, got_n}, 1);
`endif

        // Backpressure
        rsp_ready = 1'b0;
        issue(16'h00FF, 16'h0F0F, 4'b0110, 1'b1, 1'b0);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (d_valid) lat = k;
        end
        chk("bp_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_a = 16'h1111 * i[15:0]; req_b = 16'h2222;
            chk("bp_valid", {31'd0, d_valid}, 1);
            chk("bp_ready", {31'd0, d_ready}, 0);
            chk("bp_f", {16'd0, d_f}, 32'h0FF0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("bp_valid_end", {31'd0, d_valid}, 1);
        @(negedge clk);
        chk("bp_idle_ready", {31'd0, d_ready}, 1);
        chk("bp_idle_valid", {31'd0, d_valid}, 0);
        @(negedge clk);
        chk("bp_no_accept", {31'd0, d_ready}, 1);

        // ALU_WAIT=2 instance
        sel = 1'b1;
        op("w2", 16'h5AA5, 16'h0F0F, 4'b0110, 1'b1, 1'b0, 16'h55AA, 1'b0, 1'b0, 7);
        for (int k = 1; k <= 3; k++) chk("w2_lo_hold", {24'd0, tr_a[k]}, 32'hA5);
        for (int k = 4; k <= 6; k++) chk("w2_hi_hold", {24'd0, tr_a[k]}, 32'h5A);

        // Reset in HI aborts
        issue(16'h5AA5, 16'h0F0F, 4'b0110, 1'b1, 1'b0);
        watch(4);
        chk("w2_in_hi", {24'd0, tr_a[4]}, 32'h5A);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_ready", {31'd0, rr1}, 1);
        chk("abort_valid", {31'd0, vv1}, 0);
        chk("abort_f", {16'd0, rf1}, 0);
        watch(10);
        chk("abort_no_rsp", width, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
